// File: rtl/cmp_arbiter.sv
// Shared registered subtract/compare unit. NREQ requesters offer operand pairs,
// a round-robin arbiter picks one, and a 3-state FSM returns {N,Z,C,V} with the winner's ID.
module cmp_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [3:0]          rsp_flag,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [IDW-1:0] r_rr_ptr;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IDW-1:0] r_id;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [3:0]     r_rsp_flag;

  logic           w_found;
  logic [IDW-1:0] w_grant_id;
  logic [W-1:0]   w_grant_a;
  logic [W-1:0]   w_grant_b;
  logic [W:0]     w_diff;
  logic [3:0]     w_flag;
  logic           w_accept;
  logic [IDW-1:0] w_ptr_nxt;

  // Round-robin scan starting at r_rr_ptr; the first valid requester wins
  // and its operands are muxed out in the same pass.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_grant_a  = '0;
    w_grant_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_grant_id = idx[IDW-1:0];
        w_grant_a  = req_a[idx*W +: W];
        w_grant_b  = req_b[idx*W +: W];
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_ptr_nxt = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_grant_id] = 1'b1;
  end

  // Unsigned subtract with the extra top bit serving as the borrow.
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_flag = {w_diff[W-1],
                   (w_diff[W-1:0] == '0),
                   w_diff[W],
                   (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1])};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_flag  <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= w_grant_a;
        r_b      <= w_grant_b;
        r_id     <= w_grant_id;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == S_EXEC) begin
        r_rsp_flag  <= w_flag;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      // rsp_ready is only honoured while a result is actually presented.
      if ((r_state == S_RESP) && r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_flag  = r_rsp_flag;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, single op, flag arithmetic, round robin,
// back-pressure and pointer wrap, with hand-computed expectations.
module tb_cmp_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_flag;
  logic              busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  cmp_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_flag  (rsp_flag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One complete op from a lone requester with rsp_ready held high.
  task automatic do_op(input string tag, input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [3:0] exp_flag);
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[i] = 1'b1;
    set_req(i, a, b);
    req_valid = exp_rdy;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    req_valid = '0;
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(i));
    check({tag, "_flag"},  32'(rsp_flag),  32'(exp_flag));
    tick();
    check({tag, "_done"},  32'(busy),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_flag",  32'(rsp_flag),  32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single op, equal operands: Z only. Pointer moves to 2.
    do_op("single", 1, 32'd5, 32'd5, 4'b0100);

    // Flag arithmetic; each lone requester also walks the pointer 2->3->0->1->2.
    do_op("f_3_ffff", 2, 32'd3,          32'hFFFF_FFFF, 4'b0010);
    do_op("f_3_5",    3, 32'd3,          32'd5,         4'b1010);
    do_op("f_min_1",  0, 32'h8000_0000,  32'd1,         4'b0001);
    do_op("f_max_m1", 1, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 4'b1011);

    // Reset mid-EXEC: pointer is 3 after this accept, reset must return it to 0.
    set_req(2, 32'd9, 32'd1);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    #1;
    check("exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_busy",  32'(busy),      32'd0);
    check("mrst_id",    32'(rsp_id),    32'd0);
    check("mrst_flag",  32'(rsp_flag),  32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mrst_noresp", 32'(rsp_valid), 32'd0);
    end

    // Round robin with all four valid: 0,1,2,3,0. Equal operands give Z.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 7), 32'(i + 7));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) begin
        #1;
        check("rr_grant", 32'(req_ready), 32'(4'b0001 << order[n]));
        tick();
        tick();
        check("rr_id",   32'(rsp_id),   32'(order[n]));
        check("rr_flag", 32'(rsp_flag), 32'(4'b0100));
        tick();
      end
    end
    req_valid = '0;

    // Pointer is 1; serve req2 alone, then {0,3} must go to 3.
    do_op("rr_req2", 2, 32'd1, 32'd1, 4'b0100);
    req_valid = 4'b1001;
    #1;
    check("rr_after2", 32'(req_ready), 32'(4'b1000));
    tick();
    req_valid = '0;
    tick();
    tick();

    // Back-pressure: pointer is 0. 10-20 gives N and C.
    set_req(0, 32'd10, 32'd20);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id",    32'(rsp_id),    32'd0);
      check("bp_flag",  32'(rsp_flag),  32'(4'b1010));
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy",  32'(busy),      32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    check("bp_release", 32'(rsp_valid), 32'd0);
    check("bp_idle",    32'(busy),      32'd0);

    // Wrap and sparse: pointer 1 -> req2 op leaves it at 3; lone req1 then wins
    // and the pointer becomes 2, so an all-valid grant must go to 2.
    do_op("wrap_req2", 2, 32'd4, 32'd2, 4'b0000);
    do_op("wrap_req1", 1, 32'd2, 32'd4, 4'b1010);
    req_valid = 4'b1111;
    #1;
    check("wrap_ptr", 32'(req_ready), 32'(4'b0100));
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
